// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream offer, downstream
// release and the hazard controls (stall/flush) that steer them.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              stall;
  logic              flush;
  logic [1:0]        count;

  // The stage itself: consumes the offer and hazard controls, presents the held entry.
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready, stall, flush,
    output in_ready, out_valid, out_ctrl, out_data, count
  );

  // The surrounding pipeline: upstream producer, downstream consumer and hazard unit.
  modport master (
    output in_valid, in_ctrl, in_data, out_ready, stall, flush,
    input  in_ready, out_valid, out_ctrl, out_data, count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, stall, flush
// and an optional skid entry that decouples in_ready from out_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 64,
  parameter int SKID   = 0
) (
  input logic               clk,
  input logic               rst_n,
  pipe_stage_reg_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]        count_q, count_d;
  logic              live_q, live_d;

  logic              in_ready_s;
  logic              accept_s;
  logic              release_s;

  // Handshake qualifiers; live_q keeps in_ready low until the first edge after reset.
  always_comb begin
    in_ready_s = 1'b0;
    if (SKID != 0) begin
      in_ready_s = live_q & (state_q != ST_FULL) & ~bus.stall & ~bus.flush;
    end else begin
      in_ready_s = live_q & ~bus.stall & ~bus.flush & (~out_valid_q | bus.out_ready);
    end
    accept_s  = bus.in_valid & in_ready_s;
    release_s = out_valid_q & bus.out_ready & ~bus.stall;
  end

  // Next-state and next-entry selection; flush outranks stall and release.
  always_comb begin
    state_d     = state_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    live_d      = 1'b1;

    if (bus.flush) begin
      state_d     = ST_EMPTY;
      out_ctrl_d  = {CTRL_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d    = ST_ONE;
            out_ctrl_d = bus.in_ctrl;
            out_data_d = bus.in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && release_s) begin
            out_ctrl_d = bus.in_ctrl;
            out_data_d = bus.in_data;
          end else if (accept_s) begin
            // Only reachable with a skid entry: main is stuck, so park the newcomer.
            state_d     = ST_FULL;
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
          end else if (release_s) begin
            state_d    = ST_EMPTY;
            out_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (release_s) begin
            state_d     = ST_ONE;
            out_ctrl_d  = skid_ctrl_q;
            out_data_d  = skid_data_q;
            skid_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          out_ctrl_d = {CTRL_W{1'b0}};
        end
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
    count_d     = state_d;
  end

  // Stage state; reset clears every entry immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= {CTRL_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      count_q     <= 2'd0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      count_q     <= count_d;
      live_q      <= live_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;

endmodule
